// File: rtl/tlb_traductor_if.sv
// Lookup request/result and TLB fill bundle shared by the core port and the
// address-translation unit.
interface tlb_traductor_if;
  logic        start_lookup;
  logic [31:0] virt_addr;
  logic [31:0] satp;
  logic [31:0] tlb_vpn_in;
  logic [31:0] tlb_ppn_perms_in;
  logic [31:0] tlb_write_index;
  logic [31:0] phys_addr;
  logic        lookup_done;
  logic        tlb_hit;
  logic        tlb_miss;

  modport master (
    output start_lookup, virt_addr, satp, tlb_vpn_in, tlb_ppn_perms_in, tlb_write_index,
    input  phys_addr, lookup_done, tlb_hit, tlb_miss
  );

  modport slave (
    input  start_lookup, virt_addr, satp, tlb_vpn_in, tlb_ppn_perms_in, tlb_write_index,
    output phys_addr, lookup_done, tlb_hit, tlb_miss
  );
endinterface

// File: rtl/tlb_traductor.sv
// Virtual-to-physical translation through a software-filled TLB.
// Define TLB_PARALLEL_LOOKUP_EN for a single-cycle all-entry compare instead of a sequential scan.
module tlb_traductor #(
  parameter int ENTRIES = 8
) (
  input logic           clk,
  input logic           reset_n,
  tlb_traductor_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, BARE, SEARCH, RESP} state_t;

  state_t             state;
  logic [ENTRIES-1:0] ent_valid;
  logic [19:0]        ent_vpn [ENTRIES];
  logic [19:0]        ent_ppn [ENTRIES];

  logic               wr_cmd_q;
  logic               flush_cmd_q;
  logic               fill_edge;
  logic               flush_edge;
  logic [IW-1:0]      fill_idx;

  logic [31:0]        va_p0;
  logic               hit_p0;
  logic [19:0]        ppn_p0;
  logic               last_p0;
  logic               vld_p1;
  logic               hit_p1;
  logic [19:0]        ppn_p1;
  logic               last_p1;

  logic [31:0]        phys_addr_q;
  logic               done_q;
  logic               hit_q;
  logic               miss_q;

  assign fill_edge  = bus.tlb_write_index[31] & ~wr_cmd_q;
  assign flush_edge = bus.tlb_write_index[30] & ~flush_cmd_q;
  assign fill_idx   = bus.tlb_write_index[IW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cmd_q    <= 1'b0;
      flush_cmd_q <= 1'b0;
      ent_valid   <= '0;
    end else begin
      wr_cmd_q    <= bus.tlb_write_index[31];
      flush_cmd_q <= bus.tlb_write_index[30];
      if (flush_edge)
        ent_valid <= '0;
      else if (fill_edge)
        ent_valid[fill_idx] <= bus.tlb_ppn_perms_in[0];
    end
  end

  always_ff @(posedge clk) begin
    if (fill_edge && !flush_edge) begin
      ent_vpn[fill_idx] <= bus.tlb_vpn_in[19:0];
      ent_ppn[fill_idx] <= bus.tlb_ppn_perms_in[29:10];
    end
  end

  // p0: entry read and match against the captured VPN
`ifdef TLB_PARALLEL_LOOKUP_EN
  always_comb begin
    hit_p0  = 1'b0;
    ppn_p0  = '0;
    last_p0 = 1'b1;
    // Descending scan so the lowest matching index overrides the rest
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_vpn[i] == va_p0[31:12])) begin
        hit_p0 = 1'b1;
        ppn_p0 = ent_ppn[i];
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  always_comb begin
    hit_p0  = ent_valid[ptr] && (ent_vpn[ptr] == va_p0[31:12]);
    ppn_p0  = ent_ppn[ptr];
    last_p0 = (ptr == IW'(ENTRIES - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if (state == IDLE)
      ptr <= '0;
    else if (state == SEARCH && !last_p0)
      ptr <= ptr + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start_lookup)
      va_p0 <= bus.virt_addr;
    hit_p1  <= hit_p0;
    ppn_p1  <= ppn_p0;
    last_p1 <= last_p0;
  end

  // p1: decide hit/miss from the registered compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      vld_p1      <= 1'b0;
      phys_addr_q <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_lookup) begin
            phys_addr_q <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            vld_p1      <= 1'b0;
            state       <= bus.satp[31] ? SEARCH : BARE;
          end
        end
        BARE: begin
          phys_addr_q <= va_p0;
          hit_q       <= 1'b1;
          done_q      <= 1'b1;
          state       <= RESP;
        end
        SEARCH: begin
          vld_p1 <= 1'b1;
          if (vld_p1) begin
            if (hit_p1) begin
              phys_addr_q <= {ppn_p1, va_p0[11:0]};
              hit_q       <= 1'b1;
              done_q      <= 1'b1;
              state       <= RESP;
            end else if (last_p1) begin
              phys_addr_q <= '0;
              miss_q      <= 1'b1;
              done_q      <= 1'b1;
              state       <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.phys_addr   = phys_addr_q;
  assign bus.lookup_done = done_q;
  assign bus.tlb_hit     = hit_q;
  assign bus.tlb_miss    = miss_q;

  logic unused_bits;
  assign unused_bits = ^{bus.tlb_vpn_in[31:20], bus.tlb_ppn_perms_in[31:30],
                         bus.tlb_ppn_perms_in[9:1], bus.tlb_write_index[29:IW],
                         bus.satp[30:0]};
endmodule

// File: tb/tb_tlb_traductor.sv
// Directed bench for tlb_traductor: bare mode, hit/miss latency, priority,
// flush, ignored restart and mid-search reset.
module tb_tlb_traductor;
  localparam int ENTRIES = 8;
  localparam int W       = 24;
`ifdef TLB_PARALLEL_LOOKUP_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tlb_traductor_if bus ();
  tlb_traductor #(.ENTRIES(ENTRIES)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int compared = 0;
  int failed   = 0;

  int          lat;
  int          pulses;
  logic [31:0] pa;
  logic        h;
  logic        m;
  logic        stable;

  function automatic int hit_lat(input int j);
    return PAR ? 3 : 3 + j;
  endfunction

  function automatic int miss_lat();
    return PAR ? 3 : 2 + ENTRIES;
  endfunction

  task automatic fill(input int idx, input logic [19:0] vpn, input logic [19:0] ppn, input logic v);
    @(negedge clk);
    bus.tlb_vpn_in       = {12'h0, vpn};
    bus.tlb_ppn_perms_in = {2'b00, ppn, 9'h0, v};
    bus.tlb_write_index  = 32'h8000_0000 | 32'(idx);
    @(negedge clk);
    bus.tlb_write_index  = 32'h0;
  endtask

  task automatic flush();
    @(negedge clk);
    bus.tlb_write_index = 32'h4000_0000;
    @(negedge clk);
    bus.tlb_write_index = 32'h0;
  endtask

  // Issues one lookup and watches a fixed window; inputs are scrambled after capture.
  task automatic do_lookup(input logic [31:0] va, input logic [31:0] sp, input int dup_at);
    @(negedge clk);
    bus.virt_addr    = va;
    bus.satp         = sp;
    bus.start_lookup = 1'b1;
    @(posedge clk);
    lat = -1; pulses = 0; pa = '0; h = 1'b0; m = 1'b0; stable = 1'b1;
    for (int n = 1; n <= W; n++) begin
      @(negedge clk);
      bus.start_lookup = (n == dup_at);
      if (n >= 2) begin
        bus.virt_addr = ~va;
        bus.satp      = ~sp;
      end
      if (bus.lookup_done) begin
        pulses++;
        if (lat < 0) begin
          lat = n; pa = bus.phys_addr; h = bus.tlb_hit; m = bus.tlb_miss;
        end
      end else if (lat >= 0) begin
        if (bus.phys_addr !== pa || bus.tlb_hit !== h || bus.tlb_miss !== m) stable = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    bus.start_lookup = 1'b0; bus.virt_addr = '0; bus.satp = '0;
    bus.tlb_vpn_in = '0; bus.tlb_ppn_perms_in = '0; bus.tlb_write_index = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (bus.phys_addr !== 32'h0) begin failed++; $display("FAIL reset_phys: got %h expected 00000000", bus.phys_addr); end
    compared++; if (bus.lookup_done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b expected 0", bus.lookup_done); end
    compared++; if (bus.tlb_hit !== 1'b0) begin failed++; $display("FAIL reset_hit: got %b expected 0", bus.tlb_hit); end
    compared++; if (bus.tlb_miss !== 1'b0) begin failed++; $display("FAIL reset_miss: got %b expected 0", bus.tlb_miss); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bare();
    do_lookup(32'h0000_1234, 32'h0, 0);
    compared++; if (lat !== 2) begin failed++; $display("FAIL bare_latency: got %0d expected 2", lat); end
    compared++; if (pa !== 32'h0000_1234) begin failed++; $display("FAIL bare_phys: got %h expected 00001234", pa); end
    compared++; if (h !== 1'b1 || m !== 1'b0) begin failed++; $display("FAIL bare_flags: got hit=%b miss=%b expected hit=1 miss=0", h, m); end
    compared++; if (pulses !== 1 || stable !== 1'b1) begin failed++; $display("FAIL bare_pulse: got pulses=%0d stable=%b expected 1/1", pulses, stable); end
  endtask

  task automatic test_fill_hit();
    fill(3, 20'h80001, 20'h00042, 1'b1);
    do_lookup(32'h8000_1ABC, 32'h8000_0000, 0);
    compared++; if (lat !== hit_lat(3)) begin failed++; $display("FAIL hit3_latency: got %0d expected %0d", lat, hit_lat(3)); end
    compared++; if (pa !== 32'h0004_2ABC) begin failed++; $display("FAIL hit3_phys: got %h expected 00042abc", pa); end
    compared++; if (h !== 1'b1 || m !== 1'b0) begin failed++; $display("FAIL hit3_flags: got hit=%b miss=%b expected hit=1 miss=0", h, m); end
    compared++; if (pulses !== 1 || stable !== 1'b1) begin failed++; $display("FAIL hit3_pulse: got pulses=%0d stable=%b expected 1/1", pulses, stable); end
  endtask

  task automatic test_miss();
    fill(3, 20'h80001, 20'h00042, 1'b0);
    do_lookup(32'h8000_1ABC, 32'h8000_0000, 0);
    compared++; if (lat !== miss_lat()) begin failed++; $display("FAIL miss_latency: got %0d expected %0d", lat, miss_lat()); end
    compared++; if (pa !== 32'h0) begin failed++; $display("FAIL miss_phys: got %h expected 00000000", pa); end
    compared++; if (h !== 1'b0 || m !== 1'b1) begin failed++; $display("FAIL miss_flags: got hit=%b miss=%b expected hit=0 miss=1", h, m); end
  endtask

  task automatic test_priority_flush();
    fill(2, 20'h00010, 20'h00AAA, 1'b1);
    fill(5, 20'h00010, 20'h00BBB, 1'b1);
    do_lookup(32'h0001_0004, 32'h8000_0000, 0);
    compared++; if (lat !== hit_lat(2)) begin failed++; $display("FAIL prio_latency: got %0d expected %0d", lat, hit_lat(2)); end
    compared++; if (pa !== 32'h00AA_A004) begin failed++; $display("FAIL prio_phys: got %h expected 00aaa004", pa); end
    compared++; if (h !== 1'b1 || m !== 1'b0) begin failed++; $display("FAIL prio_flags: got hit=%b miss=%b expected hit=1 miss=0", h, m); end
    flush();
    do_lookup(32'h0001_0004, 32'h8000_0000, 0);
    compared++; if (lat !== miss_lat()) begin failed++; $display("FAIL flush_latency: got %0d expected %0d", lat, miss_lat()); end
    compared++; if (h !== 1'b0 || m !== 1'b1 || pa !== 32'h0) begin failed++; $display("FAIL flush_result: got hit=%b miss=%b phys=%h expected 0/1/00000000", h, m, pa); end
  endtask

  task automatic test_last_entry();
    fill(7, 20'h0ABCD, 20'hFFFFF, 1'b1);
    do_lookup(32'h0ABC_DFFF, 32'h8000_0000, 0);
    compared++; if (lat !== hit_lat(ENTRIES - 1)) begin failed++; $display("FAIL last_latency: got %0d expected %0d", lat, hit_lat(ENTRIES - 1)); end
    compared++; if (pa !== 32'hFFFF_FFFF || h !== 1'b1 || m !== 1'b0) begin failed++; $display("FAIL last_result: got phys=%h hit=%b miss=%b expected ffffffff/1/0", pa, h, m); end
  endtask

  task automatic test_back_to_back();
    do_lookup(32'h0ABC_D123, 32'h8000_0000, 2);
    compared++; if (pulses !== 1) begin failed++; $display("FAIL dup_pulses: got %0d expected 1", pulses); end
    compared++; if (lat !== hit_lat(ENTRIES - 1)) begin failed++; $display("FAIL dup_latency: got %0d expected %0d", lat, hit_lat(ENTRIES - 1)); end
    compared++; if (pa !== 32'hFFFF_F123 || h !== 1'b1) begin failed++; $display("FAIL dup_result: got phys=%h hit=%b expected fffff123/1", pa, h); end
    compared++; if (stable !== 1'b1) begin failed++; $display("FAIL dup_stable: got %b expected 1", stable); end
  endtask

  task automatic test_reset_mid_search();
    int p;
    fill(6, 20'h12345, 20'h00777, 1'b1);
    @(negedge clk);
    bus.virt_addr = 32'h1234_5678; bus.satp = 32'h8000_0000; bus.start_lookup = 1'b1;
    @(posedge clk);
    p = 0;
    for (int n = 1; n <= W; n++) begin
      @(negedge clk);
      bus.start_lookup = 1'b0;
      if (n == 2) begin
        reset_n = 1'b0;
        #1;
        compared++; if (bus.phys_addr !== 32'h0 || bus.tlb_hit !== 1'b0 || bus.tlb_miss !== 1'b0 || bus.lookup_done !== 1'b0) begin failed++; $display("FAIL midreset_outputs: got phys=%h hit=%b miss=%b done=%b expected all 0", bus.phys_addr, bus.tlb_hit, bus.tlb_miss, bus.lookup_done); end
      end
      if (n == 3) reset_n = 1'b1;
      if (bus.lookup_done) p++;
    end
    compared++; if (p !== 0) begin failed++; $display("FAIL midreset_pulses: got %0d expected 0", p); end
    do_lookup(32'h1234_5678, 32'h8000_0000, 0);
    compared++; if (lat !== miss_lat()) begin failed++; $display("FAIL postreset_latency: got %0d expected %0d", lat, miss_lat()); end
    compared++; if (h !== 1'b0 || m !== 1'b1 || pa !== 32'h0) begin failed++; $display("FAIL postreset_result: got hit=%b miss=%b phys=%h expected 0/1/00000000", h, m, pa); end
  endtask

  initial begin
    test_reset();
    test_bare();
    test_fill_hit();
    test_miss();
    test_priority_flush();
    test_last_entry();
    test_back_to_back();
    test_reset_mid_search();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
